mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU, IO/loader) arbiter in front of a single-port
// RAM with registered read data. Each transaction walks IDLE -> ACCESS -> DONE;
// the ack (and read data) appears on the edge that leaves DONE, i.e. two edges
// after the grant edge.
//
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata             CPU completion pulse and read data
//   io_req/we/addr/wdata           IO/loader request
//   io_ack, io_rdata               IO completion pulse and read data
//   ram_read, ram_write            one-cycle RAM strobes (ACCESS only)
//   ram_addr, ram_wdata            latched address / write data to RAM
//   ram_rdata                      RAM read data, valid one cycle after ram_read
//   busy                           high whenever the FSM is not in IDLE
//
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// without it the CPU always wins ties.
module mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_ack,
    output logic [DW-1:0] io_rdata,
    output logic          ram_read,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        r_state;
    logic          r_we;
    logic          r_owner_io;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_ram_read;
    logic          r_ram_write;
    logic          r_busy;
    logic          r_cpu_ack;
    logic          r_io_ack;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_io_rdata;

    logic          w_any_req;
    logic          w_grant_io;
    logic          w_we;

    assign w_any_req = cpu_req | io_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = IO was granted last; reset value lets the CPU win the first tie.
    logic r_last_io;
    assign w_grant_io = io_req & (~cpu_req | ~r_last_io);
`else
    assign w_grant_io = io_req & ~cpu_req;
`endif

    assign w_we = w_grant_io ? io_we : cpu_we;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_owner_io  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
            r_busy      <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_io_ack    <= 1'b0;
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_io   <= 1'b1;
`endif
        end else begin
            r_cpu_ack <= 1'b0;
            r_io_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        // Latch the winner; requester inputs are ignored from here on.
                        r_owner_io  <= w_grant_io;
                        r_we        <= w_we;
                        r_addr      <= w_grant_io ? io_addr  : cpu_addr;
                        r_wdata     <= w_grant_io ? io_wdata : cpu_wdata;
                        r_ram_read  <= ~w_we;
                        r_ram_write <= w_we;
                        r_busy      <= 1'b1;
                        r_state     <= ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last_io   <= w_grant_io;
`endif
                    end
                end
                ACCESS: begin
                    r_ram_read  <= 1'b0;
                    r_ram_write <= 1'b0;
                    r_state     <= DONE;
                end
                DONE: begin
                    // ram_rdata is valid now, one cycle after the read strobe.
                    if (r_owner_io) begin
                        r_io_ack <= 1'b1;
                        if (!r_we) r_io_rdata <= ram_rdata;
                    end else begin
                        r_cpu_ack <= 1'b1;
                        if (!r_we) r_cpu_rdata <= ram_rdata;
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ram_read  <= 1'b0;
                    r_ram_write <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign io_ack    = r_io_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign io_rdata  = r_io_rdata;
    assign ram_read  = r_ram_read;
    assign ram_write = r_ram_write;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple registered-read RAM model.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          io_req = 1'b0, io_we = 1'b0;
    logic [AW-1:0] io_addr = '0;
    logic [DW-1:0] io_wdata = '0;
    logic          io_ack;
    logic [DW-1:0] io_rdata;
    logic          ram_read, ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 CLK = ~CLK;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    // RAM model: synchronous write, registered read.
    always @(posedge CLK) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        if (ram_read)  ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobes must never overlap.
    always @(negedge CLK) if (!RST) chk("strobe_overlap", {31'd0, ram_read & ram_write}, 32'd0);

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_acks_strobes_busy", {27'd0, cpu_ack, io_ack, ram_read, ram_write, busy}, 32'd0);
        chk("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
        chk("rst_rdata", {cpu_rdata, io_rdata}, 32'd0);
        RST = 1'b0;

        // CPU write 0x010 <- 0xBEEF
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h010; cpu_wdata = 16'hBEEF;
        tick(); // after grant edge: ACCESS
        chk("wr_strobe", {30'd0, ram_read, ram_write}, 32'd1);
        chk("wr_addr", {20'd0, ram_addr}, 32'h010);
        chk("wr_data", {16'd0, ram_wdata}, 32'hBEEF);
        chk("wr_busy_noack", {30'd0, busy, cpu_ack}, 32'b10);
        tick(); // DONE
        chk("wr_strobe_1cyc", {30'd0, ram_read, ram_write}, 32'd0);
        chk("wr_done_noack", {30'd0, busy, cpu_ack}, 32'b10);
        tick(); // ack cycle
        chk("wr_ack", {30'd0, cpu_ack, io_ack}, 32'b10);
        chk("wr_ack_idle", {31'd0, busy}, 32'd0);
        cpu_req = 0;
        tick();
        chk("wr_ack_pulse", {29'd0, cpu_ack, busy, ram_write}, 32'd0);

        // CPU read 0x010
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010; cpu_wdata = 16'h0000;
        tick();
        chk("rd_strobe", {30'd0, ram_read, ram_write}, 32'b10);
        tick();
        tick();
        chk("rd_ack", {30'd0, cpu_ack, io_ack}, 32'b10);
        chk("rd_data", {16'd0, cpu_rdata}, 32'hBEEF);
        cpu_req = 0;
        tick();
        chk("rd_io_quiet", {30'd0, io_ack, cpu_ack}, 32'd0);
        chk("rd_data_held", {16'd0, cpu_rdata}, 32'hBEEF);

        // Both requesting continuously; pointer freshly reset.
        do_reset();
        chk("rst2_rdata", {16'd0, cpu_rdata}, 32'd0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h001;
        io_req = 1; io_we = 1; io_addr = 12'h002; io_wdata = 16'h1234;
        for (int i = 0; i < 9; i++) begin
            logic [1:0] exp_acks;
            tick();
            exp_acks = 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (i == 2 || i == 8) exp_acks = 2'b10;
            if (i == 5)           exp_acks = 2'b01;
`else
            if (i == 2 || i == 5 || i == 8) exp_acks = 2'b10;
`endif
            chk($sformatf("tie_acks_%0d", i), {30'd0, cpu_ack, io_ack}, {30'd0, exp_acks});
        end
        cpu_req = 0; io_req = 0;
        tick(); tick(); tick(); tick();

        // IO write in progress, CPU request arrives during ACCESS
        io_req = 1; io_we = 1; io_addr = 12'h020; io_wdata = 16'h5A5A;
        tick();
        chk("io_wr_strobe", {30'd0, ram_read, ram_write}, 32'b01);
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h020;
        tick();
        chk("io_addr_held", {20'd0, ram_addr}, 32'h020);
        tick();
        chk("io_ack_first", {30'd0, cpu_ack, io_ack}, 32'b01);
        io_req = 0;
        tick();
        chk("cpu_after_io", {30'd0, ram_read, ram_write}, 32'b10);
        tick(); tick();
        chk("cpu_ack_after_io", {30'd0, cpu_ack, io_ack}, 32'b10);
        chk("cpu_rd_io_data", {16'd0, cpu_rdata}, 32'h5A5A);
        chk("io_rdata_untouched", {16'd0, io_rdata}, 32'd0);
        cpu_req = 0;
        tick(); tick();

        // Reset during ACCESS of an IO write
        io_req = 1; io_we = 1; io_addr = 12'h030; io_wdata = 16'h7777;
        tick();
        chk("abort_pre_strobe", {31'd0, ram_write}, 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("abort_strobe_drop", {29'd0, ram_write, ram_read, busy}, 32'd0);
        chk("abort_addr", {20'd0, ram_addr}, 32'd0);
        chk("abort_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        io_req = 0;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort_quiet_%0d", i), {29'd0, io_ack, busy, ram_write}, 32'd0);
        end

        // CPU drops req one cycle after the grant
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h040; cpu_wdata = 16'h0042;
        tick();
        chk("drop_strobe", {31'd0, ram_write}, 32'd1);
        cpu_req = 0;
        tick();
        tick();
        chk("drop_ack", {31'd0, cpu_ack}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("drop_no_second_%0d", i), {28'd0, cpu_ack, busy, ram_write, ram_read}, 32'd0);
        end
        chk("drop_mem", {16'd0, mem[12'h040]}, 32'h0042);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
